difftest_int_wb_sched: RTL and testbench

- Collects integer-register writeback records from several commit/writeback lanes and serialises them onto the single per-cycle difftest integer-writeback port (io_valid/io_dest/io_data/io_coreid).
- Each lane has its own small FIFO. A round-robin arbiter drains one record per cycle into a registered output stage.
- Sits between the core's writeback lanes and the difftest integer-writeback DPI wrapper.

---
 rtl/difftest_wb_pkg.sv | 16 +
 rtl/difftest_wb_fifo.sv | 58 +++++
 rtl/difftest_int_wb_sched.sv | 120 ++++++++++++
 tb/tb_difftest_int_wb_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_wb_pkg.sv
// Purpose: shared types and widths for the difftest integer-writeback scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package difftest_wb_pkg;

  localparam int WB_DEST_W = 32;
  localparam int WB_DATA_W = 64;
  localparam int CNT_W     = 32;

  // One integer-register writeback record as carried through the lane FIFOs.
  typedef struct packed {
    logic [WB_DEST_W-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_rec_t;

endpackage

// File: rtl/difftest_wb_fifo.sv
// Purpose: single-lane synchronous FIFO of writeback records.
// Latency: a record pushed at edge t is visible at head after edge t (readable in the next cycle).
// Backpressure: full is derived from the registered count only; pushes while full are ignored.
module difftest_wb_fifo
  import difftest_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   io_clock,
  input  logic                   io_reset,
  input  logic                   push,
  input  wb_rec_t                push_rec,
  input  logic                   pop,
  output wb_rec_t                head,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wb_rec_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (cnt_q != '0);
  assign head    = mem[rd_ptr];
  assign count   = cnt_q;

  // Storage write; entry validity is tracked by cnt_q, so no reset is needed here.
  always_ff @(posedge io_clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_rec;
    end
  end

  // Wrapping pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/difftest_int_wb_sched.sv
// Purpose: serialise per-lane integer writeback records onto one difftest port via round-robin.
// Latency: 2 cycles from lane acceptance to io_out_valid when uncontended; 1 record/cycle total.
// Backpressure: per-lane ready = FIFO not full; the output side is never stalled.
module difftest_int_wb_sched
  import difftest_wb_pkg::*;
#(
  parameter int NLANE   = 4,
  parameter int DEPTH   = 4,
  parameter int DROP_X0 = 1
) (
  input  logic                       io_clock,
  input  logic                       io_reset,
  input  logic [7:0]                 io_coreid,
  input  logic [NLANE-1:0]           io_in_valid,
  output logic [NLANE-1:0]           io_in_ready,
  input  logic [NLANE*WB_DEST_W-1:0] io_in_dest,
  input  logic [NLANE*WB_DATA_W-1:0] io_in_data,
  output logic                       io_out_valid,
  output logic [7:0]                 io_out_coreid,
  output logic [WB_DEST_W-1:0]       io_out_dest,
  output logic [WB_DATA_W-1:0]       io_out_data,
  output logic                       io_idle,
  output logic [CNT_W-1:0]           io_out_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (NLANE > 1) ? $clog2(NLANE) : 1;

  wb_rec_t          in_rec   [NLANE];
  wb_rec_t          head     [NLANE];
  logic [CW-1:0]    count    [NLANE];
  logic [NLANE-1:0] push;
  logic [NLANE-1:0] pop;
  logic [NLANE-1:0] full;
  logic [NLANE-1:0] nonempty;

  logic             gnt_vld;
  logic [RW-1:0]    gnt_idx;
  logic [RW-1:0]    rr_q;

  logic                 out_vld_q;
  logic [7:0]           out_coreid_q;
  logic [WB_DEST_W-1:0] out_dest_q;
  logic [WB_DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]     out_count_q;

  // Lane index base+off modulo NLANE (off < NLANE).
  function automatic logic [RW-1:0] lane_at(input logic [RW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NLANE) s = s - NLANE;
    return RW'(s);
  endfunction

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    assign in_rec[i].dest = io_in_dest[WB_DEST_W*i +: WB_DEST_W];
    assign in_rec[i].data = io_in_data[WB_DATA_W*i +: WB_DATA_W];
    // x0 writes still complete the handshake but never occupy a slot.
    assign push[i]        = io_in_valid[i] && !((DROP_X0 != 0) && (in_rec[i].dest == '0));
    assign pop[i]         = gnt_vld && (gnt_idx == RW'(i));
    assign nonempty[i]    = (count[i] != '0);
    assign io_in_ready[i] = !full[i];

    difftest_wb_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .io_clock(io_clock),
      .io_reset(io_reset),
      .push    (push[i]),
      .push_rec(in_rec[i]),
      .pop     (pop[i]),
      .head    (head[i]),
      .full    (full[i]),
      .count   (count[i])
    );
  end

  // Round-robin pick: first nonempty lane scanning rr_q, rr_q+1, ... (reverse loop so lowest offset wins).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NLANE - 1; k >= 0; k--) begin
      if (nonempty[lane_at(rr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = lane_at(rr_q, k);
      end
    end
  end

  // Output register, rr pointer and saturating emit counter.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      rr_q         <= '0;
      out_vld_q    <= 1'b0;
      out_coreid_q <= '0;
      out_dest_q   <= '0;
      out_data_q   <= '0;
      out_count_q  <= '0;
    end else begin
      out_vld_q    <= gnt_vld;
      out_coreid_q <= io_coreid;
      if (gnt_vld) begin
        out_dest_q <= head[gnt_idx].dest;
        out_data_q <= head[gnt_idx].data;
        rr_q       <= lane_at(gnt_idx, 1);
      end
      if (out_vld_q && (out_count_q != '1)) begin
        out_count_q <= out_count_q + 1'b1;
      end
    end
  end

  assign io_out_valid  = out_vld_q;
  assign io_out_coreid = out_coreid_q;
  assign io_out_dest   = out_dest_q;
  assign io_out_data   = out_data_q;
  assign io_out_count  = out_count_q;
  assign io_idle       = (nonempty == '0) && !out_vld_q;

endmodule

// File: tb/tb_difftest_int_wb_sched.sv
// Purpose: self-checking bench for difftest_int_wb_sched using a per-lane scoreboard.
// Latency: checks the 2-cycle uncontended path and round-robin output order.
// Backpressure: exercises lane FIFO full/ready and x0 drop handshakes.
module tb_difftest_int_wb_sched;
  import difftest_wb_pkg::*;

  localparam int NLANE = 4;
  localparam int DEPTH = 4;

  typedef struct {
    int          lane;
    logic [31:0] dest;
    logic [63:0] data;
  } stim_t;

  logic                       io_clock;
  logic                       io_reset;
  logic [7:0]                 io_coreid;
  logic [NLANE-1:0]           io_in_valid;
  logic [NLANE-1:0]           io_in_ready;
  logic [NLANE*WB_DEST_W-1:0] io_in_dest;
  logic [NLANE*WB_DATA_W-1:0] io_in_data;
  logic                       io_out_valid;
  logic [7:0]                 io_out_coreid;
  logic [WB_DEST_W-1:0]       io_out_dest;
  logic [WB_DATA_W-1:0]       io_out_data;
  logic                       io_idle;
  logic [CNT_W-1:0]           io_out_count;

  difftest_int_wb_sched #(
    .NLANE  (NLANE),
    .DEPTH  (DEPTH),
    .DROP_X0(1)
  ) dut (
    .io_clock     (io_clock),
    .io_reset     (io_reset),
    .io_coreid    (io_coreid),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_dest   (io_in_dest),
    .io_in_data   (io_in_data),
    .io_out_valid (io_out_valid),
    .io_out_coreid(io_out_coreid),
    .io_out_dest  (io_out_dest),
    .io_out_data  (io_out_data),
    .io_idle      (io_idle),
    .io_out_count (io_out_count)
  );

  stim_t pend_q[$];
  stim_t exp_q[$];
  int    obs_dest[$];
  int    obs_cyc[$];
  int    acc_cnt [NLANE];
  int    emit_cnt[NLANE];
  int    cyc;
  int    n_checks;
  int    n_errors;

  logic [NLANE-1:0]           rdy_s;
  logic [NLANE-1:0]           drv_v;
  logic [NLANE*WB_DEST_W-1:0] drv_d;
  logic [NLANE*WB_DATA_W-1:0] drv_x;

  initial begin
    io_clock = 1'b0;
    forever #5 io_clock = ~io_clock;
  end

  always @(posedge io_clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic int pend_first(input int l);
    for (int i = 0; i < pend_q.size(); i++) if (pend_q[i].lane == l) return i;
    return -1;
  endfunction

  task automatic send(input int l, input logic [31:0] d, input logic [63:0] x);
    stim_t s;
    s.lane = l; s.dest = d; s.data = x;
    pend_q.push_back(s);
  endtask

  // Lane driver: holds each lane's head stimulus until accepted, then books the expectation.
  initial begin
    io_in_valid = '0;
    io_in_dest  = '0;
    io_in_data  = '0;
    forever begin
      @(negedge io_clock);
      rdy_s = io_in_ready;
      @(posedge io_clock);
      if (io_reset === 1'b0) begin
        for (int l = 0; l < NLANE; l++) begin
          if (io_in_valid[l] && rdy_s[l]) begin
            int idx;
            idx = pend_first(l);
            if (idx >= 0) begin
              if (pend_q[idx].dest != 0) exp_q.push_back(pend_q[idx]);
              pend_q.delete(idx);
              acc_cnt[l]++;
            end
          end
        end
      end
      #1;
      drv_v = '0;
      drv_d = '0;
      drv_x = '0;
      for (int l = 0; l < NLANE; l++) begin
        int idx;
        idx = pend_first(l);
        if (idx >= 0) begin
          drv_v[l]          = 1'b1;
          drv_d[32*l +: 32] = pend_q[idx].dest;
          drv_x[64*l +: 64] = pend_q[idx].data;
        end
      end
      io_in_valid = drv_v;
      io_in_dest  = drv_d;
      io_in_data  = drv_x;
    end
  end

  // Output monitor: every emitted record must match a booked one with nothing older pending on its lane.
  initial begin
    int m_idx;
    int m_old;
    forever begin
      @(negedge io_clock);
      if (io_out_valid === 1'b1) begin
        m_idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (m_idx < 0 && exp_q[i].dest == io_out_dest && exp_q[i].data == io_out_data) m_idx = i;
        end
        check_val("sb_hit", 64'(m_idx >= 0), 64'd1);
        check_val("coreid", io_out_coreid, io_coreid);
        if (m_idx >= 0) begin
          m_old = 0;
          for (int j = 0; j < m_idx; j++) if (exp_q[j].lane == exp_q[m_idx].lane) m_old = 1;
          check_val("lane_order", 64'(m_old), 64'd0);
          emit_cnt[exp_q[m_idx].lane]++;
          exp_q.delete(m_idx);
        end
        obs_dest.push_back(int'(io_out_dest));
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge io_clock);
    io_reset = 1'b1;
    pend_q.delete();
    exp_q.delete();
    @(negedge io_clock);
    io_reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(io_idle === 1'b1 && pend_q.size() == 0 && exp_q.size() == 0) && n < 200) begin
      @(negedge io_clock);
      n++;
    end
    check_val(tag, 64'(n < 200), 64'd1);
  endtask

  task automatic clear_obs();
    obs_dest.delete();
    obs_cyc.delete();
    for (int l = 0; l < NLANE; l++) begin
      acc_cnt[l]  = 0;
      emit_cnt[l] = 0;
    end
  endtask

  task automatic check_rr_burst(input string tag);
    int v;
    check_val({tag, "_n"}, 64'(obs_dest.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      v = (i < obs_dest.size()) ? obs_dest[i] : -1;
      check_val({tag, "_dest"}, 64'(v), 64'(i + 1));
      if (i > 0 && i < obs_cyc.size()) check_val({tag, "_gap"}, 64'(obs_cyc[i] - obs_cyc[0]), 64'(i));
    end
  endtask

  initial begin
    int saw_full;
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    io_reset  = 1'b1;
    io_coreid = 8'h3c;
    for (int l = 0; l < NLANE; l++) begin
      acc_cnt[l]  = 0;
      emit_cnt[l] = 0;
    end
    do_reset();

    // Reset state
    check_val("rst_valid", io_out_valid, 0);
    check_val("rst_dest", io_out_dest, 0);
    check_val("rst_data", io_out_data, 0);
    check_val("rst_coreid", io_out_coreid, 0);
    check_val("rst_count", io_out_count, 0);
    check_val("rst_idle", io_idle, 1);
    check_val("rst_ready", io_in_ready, 4'hf);

    // 1: single record on lane 2, 2-cycle latency
    send(2, 32'd5, 64'hDEAD_BEEF);
    @(negedge io_clock);
    check_val("t1_lat_c0", io_out_valid, 0);
    @(negedge io_clock);
    check_val("t1_lat_c1", io_out_valid, 0);
    @(negedge io_clock);
    check_val("t1_valid", io_out_valid, 1);
    check_val("t1_dest", io_out_dest, 5);
    check_val("t1_data", io_out_data, 64'hDEAD_BEEF);
    @(negedge io_clock);
    check_val("t1_idle", io_idle, 1);
    check_val("t1_count", io_out_count, 1);
    check_val("t1_valid_drop", io_out_valid, 0);

    // 2: all lanes at once from rr=0, then again to show rr wrapped back to 0
    do_reset();
    clear_obs();
    for (int l = 0; l < NLANE; l++) send(l, 32'(l + 1), 64'h2000 + 64'(l));
    wait_idle("t2_drain");
    check_rr_burst("t2a");
    clear_obs();
    for (int l = 0; l < NLANE; l++) send(l, 32'(l + 1), 64'h2100 + 64'(l));
    wait_idle("t2b_drain");
    check_rr_burst("t2b");

    // 3: lane 0 overfills while lanes 1-3 stay busy
    clear_obs();
    for (int k = 0; k < 6; k++) send(0, 32'h30 + 32'(k), 64'h3000 + 64'(k));
    for (int l = 1; l < NLANE; l++)
      for (int k = 0; k < 8; k++) send(l, 32'h40 + 32'(16 * l + k), 64'h3100 + 64'(16 * l + k));
    saw_full = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge io_clock);
      if (io_in_ready[0] === 1'b0) begin
        saw_full = 1;
        check_val("t3_full_occ", 64'(acc_cnt[0] - emit_cnt[0] >= DEPTH), 64'd1);
      end
      if (io_idle === 1'b1 && pend_q.size() == 0 && exp_q.size() == 0) break;
    end
    check_val("t3_saw_full", 64'(saw_full), 64'd1);
    check_val("t3_left", 64'(exp_q.size() + pend_q.size()), 64'd0);
    check_val("t3_lane0_acc", 64'(acc_cnt[0]), 64'd6);
    check_val("t3_lane0_emit", 64'(emit_cnt[0]), 64'd6);
    check_val("t3_total_emit", 64'(obs_dest.size()), 64'd30);

    // 4: x0 write is acknowledged but dropped
    do_reset();
    clear_obs();
    send(1, 32'd0, 64'h4000);
    send(1, 32'd7, 64'h4001);
    @(negedge io_clock);
    @(negedge io_clock);
    check_val("t4_x0_hs", 64'(acc_cnt[1]), 64'd1);
    wait_idle("t4_drain");
    check_val("t4_count", io_out_count, 1);
    check_val("t4_n", 64'(obs_dest.size()), 64'd1);
    if (obs_dest.size() > 0) check_val("t4_dest", 64'(obs_dest[0]), 64'd7);

    // 5: reset while three records are queued
    clear_obs();
    send(0, 32'h51, 64'h5000);
    send(1, 32'h52, 64'h5001);
    send(2, 32'h53, 64'h5002);
    @(negedge io_clock);
    @(negedge io_clock);
    check_val("t5_queued", 64'(exp_q.size()), 64'd3);
    io_reset = 1'b1;
    exp_q.delete();
    pend_q.delete();
    @(negedge io_clock);
    io_reset = 1'b0;
    check_val("t5_valid", io_out_valid, 0);
    check_val("t5_count", io_out_count, 0);
    repeat (6) @(negedge io_clock);
    check_val("t5_no_emit", 64'(obs_dest.size()), 64'd0);
    check_val("t5_idle", io_idle, 1);

    // 6: emit counter saturation
    @(negedge io_clock);
    force dut.out_count_q = 32'hFFFF_FFFE;
    @(negedge io_clock);
    release dut.out_count_q;
    @(negedge io_clock);
    check_val("t6_preload", io_out_count, 64'hFFFF_FFFE);
    clear_obs();
    for (int l = 0; l < 3; l++) send(l, 32'h60 + 32'(l), 64'h6000 + 64'(l));
    wait_idle("t6_drain");
    check_val("t6_n", 64'(obs_dest.size()), 64'd3);
    check_val("t6_sat", io_out_count, 64'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog");
  end

endmodule
